// File: rtl/int_frac_bcd_pkg.sv
// Shared types and widths for the integer/fraction to BCD converter.
package int_frac_bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int INT_DIGITS  = 3;
  localparam int INT_BITS    = 8;
  localparam int FRAC_BITS   = 8;
  localparam int INT_BCD_W   = BCD_DIGIT_W * INT_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    INT_CONV,
    FRAC_CONV,
    DONE
  } state_e;
endpackage

// File: rtl/int_frac_bcd_if.sv
// Input and output valid/ready channels of the BCD converter.
interface int_frac_bcd_if #(
  parameter int FRAC_DIGITS = 4
) ();
  import int_frac_bcd_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [INT_BITS-1:0]           int_in;
  logic [FRAC_BITS-1:0]          frac_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [INT_BCD_W-1:0]          int_bcd;
  logic [BCD_DIGIT_W*FRAC_DIGITS-1:0] frac_bcd;

  modport master (
    output in_valid, int_in, frac_in, out_ready,
    input  in_ready, out_valid, int_bcd, frac_bcd
  );

  modport slave (
    input  in_valid, int_in, frac_in, out_ready,
    output in_ready, out_valid, int_bcd, frac_bcd
  );
endinterface

// File: rtl/int_frac_bcd_converter_add3.sv
// Double-dabble correction: every BCD nibble of 5 or more gets 3 added.
module bcd_add3_adjust
  import int_frac_bcd_pkg::*;
(
  input  logic [INT_BCD_W-1:0] bcd_in,
  output logic [INT_BCD_W-1:0] bcd_out
);
  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_nibble
    logic [BCD_DIGIT_W-1:0] nib;
    assign nib = bcd_in[g*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign bcd_out[g*BCD_DIGIT_W +: BCD_DIGIT_W] =
      (nib >= 4'd5) ? nib + 4'd3 : nib;
  end
endmodule

// File: rtl/int_frac_bcd_converter.sv
// Converts an 8-bit integer part (double-dabble) and an 8-bit binary fraction
// (repeated multiply-by-10, truncating) into BCD digits, one value at a time.
module int_frac_bcd_converter
  import int_frac_bcd_pkg::*;
#(
  parameter int FRAC_DIGITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  int_frac_bcd_if.slave  bus,
  output logic           busy
);
  localparam int FRAC_W = BCD_DIGIT_W * FRAC_DIGITS;

  state_e                 state_q, state_d;
  logic [INT_BITS-1:0]    bin_q, bin_d;
  logic [INT_BCD_W-1:0]   bcd_q, bcd_d;
  logic [FRAC_BITS-1:0]   frac_q, frac_d;
  logic [FRAC_W-1:0]      digits_q, digits_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [INT_BCD_W-1:0]   int_bcd_q, int_bcd_d;
  logic [FRAC_W-1:0]      frac_bcd_q, frac_bcd_d;

  logic [INT_BCD_W-1:0]   bcd_adj;
  logic [11:0]            frac_x, prod;
  logic [FRAC_W-1:0]      digits_shift;

  bcd_add3_adjust u_add3 (
    .bcd_in  (bcd_q),
    .bcd_out (bcd_adj)
  );

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.int_bcd   = int_bcd_q;
  assign bus.frac_bcd  = frac_bcd_q;
  assign busy          = (state_q != IDLE);

  // Product stays below 4096, so the top nibble is always a decimal digit.
  assign frac_x       = {4'b0, frac_q};
  assign prod         = (frac_x << 3) + (frac_x << 1);
  assign digits_shift = (digits_q << BCD_DIGIT_W) | FRAC_W'(prod[11:8]);

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    frac_d     = frac_q;
    digits_d   = digits_q;
    cnt_d      = cnt_q;
    int_bcd_d  = int_bcd_q;
    frac_bcd_d = frac_bcd_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_d    = bus.int_in;
          frac_d   = bus.frac_in;
          bcd_d    = '0;
          digits_d = '0;
          cnt_d    = '0;
          state_d  = INT_CONV;
        end
      end
      INT_CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'(INT_BITS - 1)) begin
          cnt_d   = '0;
          state_d = FRAC_CONV;
        end
      end
      FRAC_CONV: begin
        frac_d   = prod[7:0];
        digits_d = digits_shift;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'(FRAC_DIGITS - 1)) begin
          int_bcd_d  = bcd_q;
          frac_bcd_d = digits_shift;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      frac_q     <= '0;
      digits_q   <= '0;
      cnt_q      <= '0;
      int_bcd_q  <= '0;
      frac_bcd_q <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      frac_q     <= frac_d;
      digits_q   <= digits_d;
      cnt_q      <= cnt_d;
      int_bcd_q  <= int_bcd_d;
      frac_bcd_q <= frac_bcd_d;
    end
  end
endmodule

// File: tb/tb_int_frac_bcd_converter.sv
// Directed bench for the BCD converter: vector table on a 4-digit build,
// hand sequences for backpressure and mid-conversion reset, plus an 8-digit build.
module tb_int_frac_bcd_converter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, busy8;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  int_frac_bcd_if #(.FRAC_DIGITS(4)) bus  ();
  int_frac_bcd_if #(.FRAC_DIGITS(8)) bus8 ();

  int_frac_bcd_converter #(.FRAC_DIGITS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int_frac_bcd_converter #(.FRAC_DIGITS(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus8),
    .busy (busy8)
  );

  typedef struct {
    logic [7:0]  int_in;
    logic [7:0]  frac_in;
    logic [11:0] exp_int;
    logic [15:0] exp_frac;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits for in_ready, presents one value, returns edges from accept to out_valid.
  task automatic applyStimulus(input logic [7:0] i_in, input logic [7:0] f_in, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.int_in   = i_in;
    bus.frac_in  = f_in;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  initial begin
    int lat;
    logic [11:0] held_int;
    logic [15:0] held_frac;

    vecs[0] = '{8'd200, 8'h80, 12'h200, 16'h5000};
    vecs[1] = '{8'd0,   8'h01, 12'h000, 16'h0039};
    vecs[2] = '{8'd255, 8'hFF, 12'h255, 16'h9960};
    vecs[3] = '{8'd0,   8'h00, 12'h000, 16'h0000};
    vecs[4] = '{8'd128, 8'hC0, 12'h128, 16'h7500};
    vecs[5] = '{8'd10,  8'h1A, 12'h010, 16'h1015};
    vecs[6] = '{8'd99,  8'h33, 12'h099, 16'h1992};
    vecs[7] = '{8'd59,  8'h40, 12'h059, 16'h2500};

    bus.in_valid   = 1'b0;
    bus.int_in     = '0;
    bus.frac_in    = '0;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.int_in    = '0;
    bus8.frac_in   = '0;
    bus8.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_int_bcd", 32'(bus.int_bcd), 32'd0);
    checkOutput("rst_frac_bcd", 32'(bus.frac_bcd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].int_in, vecs[v].frac_in, lat);
      checkOutput($sformatf("latency[%0d]", v), 32'(lat), 32'd12);
      checkOutput($sformatf("int_bcd[%0d]", v), 32'(bus.int_bcd), 32'(vecs[v].exp_int));
      checkOutput($sformatf("frac_bcd[%0d]", v), 32'(bus.frac_bcd), 32'(vecs[v].exp_frac));
      checkOutput($sformatf("busy_done[%0d]", v), 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("idle_out_valid[%0d]", v), 32'(bus.out_valid), 32'd0);
      checkOutput($sformatf("idle_in_ready[%0d]", v), 32'(bus.in_ready), 32'd1);
    end

    // Backpressure: result must hold while a competing input is offered.
    bus.out_ready = 1'b0;
    applyStimulus(8'd123, 8'h80, lat);
    checkOutput("bp_latency", 32'(lat), 32'd12);
    held_int  = 12'h123;
    held_frac = 16'h5000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.int_in   = 8'd7;
      bus.frac_in  = 8'h00;
      bus.in_valid = 1'b1;
      #1;
      checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("bp_int_bcd", 32'(bus.int_bcd), 32'(held_int));
      checkOutput("bp_frac_bcd", 32'(bus.frac_bcd), 32'(held_frac));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_release_busy", 32'(busy), 32'd0);
    applyStimulus(8'd7, 8'h00, lat);
    checkOutput("after_bp_latency", 32'(lat), 32'd12);
    checkOutput("after_bp_int_bcd", 32'(bus.int_bcd), 32'h007);
    checkOutput("after_bp_frac_bcd", 32'(bus.frac_bcd), 32'h0000);
    @(posedge clk);

    // Reset during the fraction phase discards the conversion.
    @(negedge clk);
    bus.int_in   = 8'd99;
    bus.frac_in  = 8'h80;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("pre_abort_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_int_bcd", 32'(bus.int_bcd), 32'd0);
    checkOutput("abort_frac_bcd", 32'(bus.frac_bcd), 32'd0);
    checkOutput("abort_in_ready_in_rst", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_in_ready_release", 32'(bus.in_ready), 32'd1);
    applyStimulus(8'd42, 8'h40, lat);
    checkOutput("fresh_latency", 32'(lat), 32'd12);
    checkOutput("fresh_int_bcd", 32'(bus.int_bcd), 32'h042);
    checkOutput("fresh_frac_bcd", 32'(bus.frac_bcd), 32'h2500);
    @(posedge clk);

    // Eight-digit build: latency grows to 16 edges.
    for (int k = 0; k < 2; k++) begin
      int guard = 0;
      @(negedge clk);
      while (!bus8.in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      bus8.int_in   = (k == 0) ? 8'd0 : 8'd255;
      bus8.frac_in  = (k == 0) ? 8'h01 : 8'hFF;
      bus8.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
      lat = 0;
      while (!bus8.out_valid && lat < 100) begin
        @(posedge clk);
        lat++;
        #1;
      end
      checkOutput($sformatf("fd8_latency[%0d]", k), 32'(lat), 32'd16);
      checkOutput($sformatf("fd8_int_bcd[%0d]", k), 32'(bus8.int_bcd),
                  (k == 0) ? 32'h000 : 32'h255);
      checkOutput($sformatf("fd8_frac_bcd[%0d]", k), bus8.frac_bcd,
                  (k == 0) ? 32'h00390625 : 32'h99609375);
      @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/int_frac_bcd_converter.md
Name: int_frac_bcd_converter

Overview:
- Downstream of the IEEE-754 int/frac extractor. Takes its 8-bit unsigned integer part and 8-bit binary fraction (weight 2^-8 per LSB).
- Produces decimal BCD digits for the display/UART stage: 3 integer digits via sequential double-dabble, then FRAC_DIGITS fraction digits via repeated multiply-by-10.
- One conversion in flight at a time. Valid/ready handshake on both sides.

Parameters:
- FRAC_DIGITS, 4, number of decimal fraction digits produced (legal 1..8); result is truncated, never rounded.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  int_in/frac_in valid
- in_ready  out  1  block can accept a new value
- int_in  in  8  unsigned integer part
- frac_in  in  8  binary fraction, value = frac_in/256
- out_valid  out  1  BCD result valid
- out_ready  in  1  consumer accepts result
- int_bcd  out  12  hundreds[11:8], tens[7:4], ones[3:0]
- frac_bcd  out  4*FRAC_DIGITS  first digit after the point in MS nibble
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - state=IDLE; int_bcd=0, frac_bcd=0, out_valid=0, busy=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
- in_ready = (state==IDLE) && !rst; combinational from state only, with no dependence on in_valid.
- Accept: in_valid && in_ready at a rising edge (edge E0) latches int_in/frac_in into working registers and moves to INT_CONV.
- INT_CONV (exactly 8 cycles):
  - Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
  - 4-bit cycle counter, cleared on entry.
  - Exit after the 8th shift.
- FRAC_CONV (exactly FRAC_DIGITS cycles):
  - p = frac_reg*10 as a 12-bit value; digit = p[11:8]; frac_reg <= p[7:0].
  - Digit is shifted into frac_bcd from the LS end.
- DONE: out_valid=1, outputs held stable until out_valid && out_ready, then IDLE.
- Latency:
  - out_valid is first high after edge E0+8+FRAC_DIGITS.
  - Earliest next accept is the edge after the output handshake, i.e. throughput is one conversion per 10+FRAC_DIGITS cycles minimum.
- Output registers update only on the transition into DONE. Intermediate values are kept in working registers, so int_bcd/frac_bcd never glitch while out_valid=1.
- in_valid outside IDLE is ignored (not latched). Upstream must hold its data.
- out_ready while not in DONE has no effect.
- Widths:
  - BCD working register is 12 bits; max int 255 gives 0x255, so there is no overflow.
  - Multiply result is at most 2550 (< 4096), so the digit is always 0..9.
- frac_in=0 yields all-zero fraction digits. No special casing is needed.
- rst mid-conversion or in DONE: abort immediately, and all outputs return to reset values next cycle. A pending result is lost.
- rst has priority over every handshake in the same cycle.

Decomposition:
- Package int_frac_bcd_pkg:
  - state enum {IDLE, INT_CONV, FRAC_CONV, DONE}
  - BCD_DIGIT_W=4, INT_DIGITS=3, INT_BITS=8, FRAC_BITS=8
- One natural sub-module: bcd_add3_adjust. It is combinational; it takes a 12-bit BCD value and returns each nibble incremented by 3 when >= 5. It is instantiated once in INT_CONV.
- Multiply-by-10 is inline as (x<<3)+(x<<1).

Test Plan:
- Reset, then int_in=200, frac_in=0x80, out_ready=1 -> out_valid after E0+12 edges; int_bcd=0x200, frac_bcd=0x5000.
- int_in=0, frac_in=0x01 -> int_bcd=0x000, frac_bcd=0x0039 (0.00390625 truncated).
- int_in=255, frac_in=0xFF -> int_bcd=0x255, frac_bcd=0x9960.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid with int_in=7 is ignored. Then out_ready=1 -> IDLE, next accept converts 7 correctly.
- rst pulsed during FRAC_CONV of int_in=99 -> next cycle out_valid=0, int_bcd=0, busy=0, in_ready=1 after release. A fresh conversion of int_in=42, frac_in=0x40 gives 0x042 / 0x2500.
- FRAC_DIGITS=8 build: frac_in=0x01 -> frac_bcd=0x00390625, latency 16 edges.
